led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
//
// PURPOSE
//   Scan/readout engine for a 64x64, 1/32-scan HUB75 panel. Issues
//   (frame, subframe, x, y) pixel requests to the painter24 pixel pipeline.
//   Captures the rgb24 results after the pipeline's fixed latency.
//   Converts each pixel to PWM bits and drives the panel shift, latch,
//   blank and row-address lines. The top level packs these lines into
//   LED_PANEL.
//
// PARAMETERS
//   FRAME_BITS    16  width of the frame counter
//   PAINT_LAT      3  clocks from x/y request to matching rgb24 (painter24 = 3)
//   BLANK_CYCLES   3  clocks led_oe_n is held high before each latch (>=1)
//   SUBFRAMES    255  PWM subframes per frame; subframe counts 0..SUBFRAMES-1
//
// PORTS
//   clk        in   1   system clock
//   resetn     in   1   asynchronous active-low reset
//   frame      out  FB  frame counter to painter
//   subframe   out  8   PWM subframe index to painter
//   x          out  6   requested column
//   y          out  6   requested row (0..63)
//   rgb24      in   24  painter result {b,g,r}, PAINT_LAT clocks after x/y
//   led_rgb0   out  3   {b,g,r} bits for the top half (rows 0..31)
//   led_rgb1   out  3   {b,g,r} bits for the bottom half (rows 32..63)
//   led_addr   out  5   panel row address
//   led_sclk   out  1   panel shift clock
//   led_lat    out  1   panel latch strobe
//   led_oe_n   out  1   panel blank, active low
//
// BEHAVIOUR
//   Reset (async assert, sync deassert at clk):
//   - All outputs are 0 except led_oe_n=1.
//   - Counters clear; FSM enters SHIFT for row 0 with k=0.
//   FSM states: SHIFT -> BLANK -> LATCH -> SHIFT (next row).
//   SHIFT lasts 128+PAINT_LAT+1 cycles, with request counter k = 0..127.
//   - Request in cycle k: x=k[6:1]; y=row+(k[0]?32:0).
//     Even k requests the top-half pixel; odd k requests the bottom-half pixel.
//   - For k>=128 (drain), x/y hold their last value.
//   - rgb24 sampled in cycle k+PAINT_LAT belongs to request k.
//     Top results go to a holding register.
//   - On the arrival of a bottom result, led_rgb0/led_rgb1 load on that edge.
//     led_sclk=1 for exactly the next cycle, otherwise 0.
//     Result: 64 sclk pulses per row, data stable 1 cycle before each rising
//     edge of sclk.
//   - led_oe_n=0 throughout SHIFT, except the SHIFT following reset, which
//     keeps led_oe_n=1 because no row has been latched yet.
//   BLANK: led_oe_n=1 for BLANK_CYCLES cycles. led_sclk=0.
//   LATCH: one cycle with led_lat=1 and led_addr<=row (the row just shifted).
//   - Then row increments mod 32.
//   - On the 31->0 wrap, subframe increments. At SUBFRAMES-1, subframe wraps
//     to 0 and frame increments, wrapping mod 2^FRAME_BITS.
//   - frame and subframe only change at LATCH, so they are constant across
//     a row's requests and its drain.
//   PWM bit, per channel c (8 bits): bit = (c' > subframe).
//   - c' is c after the optional gamma stage.
//   - c=0 never lights. c=255 lights in all subframes when SUBFRAMES<=255.
//   rgb24 is taken as {b[23:16], g[15:8], r[7:0]}. led_rgbN = {b,g,r} bits.
//   Width rules:
//   - k is 7 bits plus a drain counter.
//   - Comparisons are unsigned 8-bit.
//   - No intermediate truncation other than the gamma >>8.
//   Reset mid-row discards the partial row. The panel is blanked immediately
//   because led_oe_n=1 asynchronously.
//
// CONFIGURATION
//   LED_SCAN_GAMMA_EN defined:
//   - c' = (c*c)>>8, computed in one extra register stage.
//   - The effective capture point becomes PAINT_LAT+1.
//   - SHIFT lengthens by 1 cycle.
//   Undefined: c' = c, linear, with no extra stage.
//
// TESTING
//   1. Reset release, rgb24 = 24'hFFFFFF constant
//      -> 64 sclk pulses, then BLANK_CYCLES cycles oe_n=1, then lat=1 with
//         addr=0, then row 1 requests begin.
//   2. Scan order: record x/y over one row -> (0,r),(0,r+32),(1,r),(1,r+32)...
//      (63,r+32). After LATCH with addr=31, subframe goes 0->1.
//   3. Model painter returns r=x, g=0, b=y, with PAINT_LAT delay
//      -> at subframe 10, rgb0.r=1 exactly for x>=11.
//      rgb1.b=1 for all x (b>=32>10).
//      Checks alignment and half pairing.
//   4. rgb24=24'h000080, gamma off -> r lit for subframe 0..127, dark 128..254.
//      Gamma on -> lit for subframe 0..63 only.
//   5. subframe=SUBFRAMES-1, row=31, frame=16'hFFFF at LATCH
//      -> subframe=0, frame=0.
//   6. Assert resetn mid-SHIFT (k=40)
//      -> led_oe_n=1 in the same cycle, all other outputs 0.
//      After release, the scan restarts at row 0, k=0.

Source files
------------

// File: rtl/led_scan_driver.sv
// HUB75 scan engine for a 64x64 1/32-scan panel: requests pixels, turns them into PWM bits and
// drives shift/latch/blank/address lines. Define LED_SCAN_GAMMA_EN for a registered (c*c)>>8 gamma.
module led_scan_driver #(
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned PAINT_LAT    = 3,
    parameter int unsigned BLANK_CYCLES = 3,
    parameter int unsigned SUBFRAMES    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    output logic [FRAME_BITS-1:0] o_frame,
    output logic [7:0]            o_subframe,
    output logic [5:0]            o_x,
    output logic [5:0]            o_y,
    input  logic [23:0]           i_rgb24,
    output logic [2:0]            o_led_rgb0,
    output logic [2:0]            o_led_rgb1,
    output logic [4:0]            o_led_addr,
    output logic                  o_led_sclk,
    output logic                  o_led_lat,
    output logic                  o_led_oe_n
);

`ifdef LED_SCAN_GAMMA_EN
    localparam int unsigned CapLat = PAINT_LAT + 1;
`else
    localparam int unsigned CapLat = PAINT_LAT;
`endif
    localparam int unsigned ShiftLen = 128 + CapLat + 1;
    localparam int unsigned CntW     = $clog2(ShiftLen);
    localparam int unsigned BlankW   = $clog2(BLANK_CYCLES + 1);

    localparam logic [CntW-1:0]   CntLast   = CntW'(ShiftLen - 1);
    localparam logic [CntW-1:0]   CntCap    = CntW'(CapLat);
    localparam logic [CntW-1:0]   CntReqEnd = CntW'(128);
    localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
    localparam logic [7:0]        SubLast   = 8'(SUBFRAMES - 1);
    localparam logic              CapOdd    = 1'(CapLat % 2);

    typedef enum logic [1:0] {StShift, StBlank, StLatch} state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [BlankW-1:0]     r_blank;
    logic [4:0]            r_row;
    logic [FRAME_BITS-1:0] r_frame;
    logic [7:0]            r_subframe;
    logic [23:0]           r_hold;
    logic [2:0]            r_rgb0;
    logic [2:0]            r_rgb1;
    logic [4:0]            r_addr;
    logic                  r_sclk;
    logic                  r_lat;
    logic                  r_oe_n;

    logic [23:0] w_pix;
    logic        w_cap;
    logic        w_bottom;

    function automatic logic [2:0] pwm_bits(input logic [23:0] pix, input logic [7:0] sf);
        return {pix[23:16] > sf, pix[15:8] > sf, pix[7:0] > sf};
    endfunction

`ifdef LED_SCAN_GAMMA_EN
    function automatic logic [7:0] gamma8(input logic [7:0] c);
        return 8'((16'(c) * 16'(c)) >> 8);
    endfunction

    logic [23:0] r_gamma;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_gamma <= '0;
        end else begin
            r_gamma <= {gamma8(i_rgb24[23:16]), gamma8(i_rgb24[15:8]), gamma8(i_rgb24[7:0])};
        end
    end

    assign w_pix = r_gamma;
`else
    assign w_pix = i_rgb24;
`endif

    // Result on w_pix belongs to request (r_cnt - CapLat); odd requests are bottom-half pixels.
    assign w_cap    = (r_state == StShift) && (r_cnt >= CntCap) && (r_cnt != CntLast);
    assign w_bottom = r_cnt[0] ^ CapOdd;

    always_comb begin
        if ((r_state == StShift) && (r_cnt < CntReqEnd)) begin
            o_x = r_cnt[6:1];
            o_y = {r_cnt[0], r_row};
        end else begin
            o_x = 6'd63;
            o_y = {1'b1, r_row};
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= StShift;
            r_cnt      <= '0;
            r_blank    <= '0;
            r_row      <= '0;
            r_frame    <= '0;
            r_subframe <= '0;
            r_hold     <= '0;
            r_rgb0     <= '0;
            r_rgb1     <= '0;
            r_addr     <= '0;
            r_sclk     <= 1'b0;
            r_lat      <= 1'b0;
            r_oe_n     <= 1'b1;
        end else begin
            r_sclk <= 1'b0;
            r_lat  <= 1'b0;
            unique case (r_state)
                StShift: begin
                    if (w_cap) begin
                        if (w_bottom) begin
                            r_rgb0 <= pwm_bits(r_hold, r_subframe);
                            r_rgb1 <= pwm_bits(w_pix, r_subframe);
                            r_sclk <= 1'b1;
                        end else begin
                            r_hold <= w_pix;
                        end
                    end
                    if (r_cnt == CntLast) begin
                        r_state <= StBlank;
                        r_cnt   <= '0;
                        r_blank <= '0;
                        r_oe_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StBlank: begin
                    if (r_blank == BlankLast) begin
                        r_state <= StLatch;
                        r_lat   <= 1'b1;
                        r_addr  <= r_row;
                    end else begin
                        r_blank <= r_blank + 1'b1;
                    end
                end
                StLatch: begin
                    // oe_n only drops here, so the shift after reset stays blanked.
                    r_state <= StShift;
                    r_oe_n  <= 1'b0;
                    r_row   <= r_row + 5'd1;
                    if (r_row == 5'd31) begin
                        if (r_subframe == SubLast) begin
                            r_subframe <= '0;
                            r_frame    <= r_frame + 1'b1;
                        end else begin
                            r_subframe <= r_subframe + 8'd1;
                        end
                    end
                end
                default: r_state <= StShift;
            endcase
        end
    end

    assign o_frame    = r_frame;
    assign o_subframe = r_subframe;
    assign o_led_rgb0 = r_rgb0;
    assign o_led_rgb1 = r_rgb1;
    assign o_led_addr = r_addr;
    assign o_led_sclk = r_sclk;
    assign o_led_lat  = r_lat;
    assign o_led_oe_n = r_oe_n;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver: reset, row timing, scan order, pairing, PWM, wrap.
module tb_led_scan_driver;

`ifdef LED_SCAN_GAMMA_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 3;
`endif
    localparam int SL    = 128 + CAP + 1;
    localparam int BLANK = 3;
    localparam int ROWP  = SL + BLANK + 1;

    logic        clk;
    logic        resetn;
    logic        resetn2;
    logic [15:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [23:0] rgb24;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic [4:0]  addr;
    logic        sclk;
    logic        lat;
    logic        oe_n;

    logic [0:0]  frame2;
    logic [7:0]  sub2;
    logic [5:0]  x2;
    logic [5:0]  y2;
    logic [23:0] rgb24_2;
    logic [2:0]  rgb0_2;
    logic [2:0]  rgb1_2;
    logic [4:0]  addr2;
    logic        sclk2;
    logic        lat2;
    logic        oe2;

    int checks;
    int failures;

    // Painter model: constant colour, or r=x, g=0, b=y after a 3-clock pipeline.
    logic        xy_mode;
    logic [23:0] const_rgb;
    logic [11:0] p1;
    logic [11:0] p2;
    logic [11:0] p3;

    always @(posedge clk) begin
        p1 <= {x, y};
        p2 <= p1;
        p3 <= p2;
    end

    assign rgb24   = xy_mode ? {2'b00, p3[5:0], 8'h00, 2'b00, p3[11:6]} : const_rgb;
    assign rgb24_2 = 24'h808080;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    led_scan_driver dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .o_frame    (frame),
        .o_subframe (subframe),
        .o_x        (x),
        .o_y        (y),
        .i_rgb24    (rgb24),
        .o_led_rgb0 (rgb0),
        .o_led_rgb1 (rgb1),
        .o_led_addr (addr),
        .o_led_sclk (sclk),
        .o_led_lat  (lat),
        .o_led_oe_n (oe_n)
    );

    led_scan_driver #(
        .FRAME_BITS (1),
        .SUBFRAMES  (2)
    ) dut_wrap (
        .i_clk      (clk),
        .i_resetn   (resetn2),
        .o_frame    (frame2),
        .o_subframe (sub2),
        .o_x        (x2),
        .o_y        (y2),
        .i_rgb24    (rgb24_2),
        .o_led_rgb0 (rgb0_2),
        .o_led_rgb1 (rgb1_2),
        .o_led_addr (addr2),
        .o_led_sclk (sclk2),
        .o_led_lat  (lat2),
        .o_led_oe_n (oe2)
    );

    function automatic logic lit(input int c, input int sf);
`ifdef LED_SCAN_GAMMA_EN
        return ((c * c) / 256) > sf;
`else
        return c > sf;
`endif
    endfunction

    task automatic wait_lat(output bit ok);
        int g;
        g = 0;
        while (lat !== 1'b1 && g < 2 * ROWP) begin
            @(negedge clk);
            g++;
        end
        ok = (lat === 1'b1);
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        resetn2   = 1'b0;
        xy_mode   = 1'b0;
        const_rgb = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (oe_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_oe_n got=%b exp=1", oe_n);
        end
        checks++;
        if ({frame, subframe, x, y} !== 36'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h exp=0", {frame, subframe, x, y});
        end
        checks++;
        if ({rgb0, rgb1, addr, sclk, lat} !== 13'd0) begin
            failures++;
            $display("FAIL reset_panel got=%b exp=0", {rgb0, rgb1, addr, sclk, lat});
        end
    endtask

    task automatic test_first_row();
        int   pulses;
        logic es;
        logic el;
        logic eo;
        pulses = 0;
        resetn = 1'b1;
        #1;
        for (int c = 0; c <= SL + BLANK + 1; c++) begin
            es = (c >= CAP + 2) && (c <= CAP + 128) && (((c - CAP) % 2) == 0);
            el = (c == SL + BLANK);
            eo = (c < SL + BLANK + 1);
            checks++;
            if ({sclk, lat, oe_n} !== {es, el, eo}) begin
                failures++;
                $display("FAIL first_row_ctrl cycle=%0d got sclk,lat,oe_n=%b%b%b exp=%b%b%b",
                         c, sclk, lat, oe_n, es, el, eo);
            end
            if (sclk === 1'b1) pulses++;
            if (c == CAP + 2) begin
                checks++;
                if ({rgb0, rgb1} !== 6'b111111) begin
                    failures++;
                    $display("FAIL first_row_white got=%b exp=111111", {rgb0, rgb1});
                end
            end
            if (c == SL + BLANK) begin
                checks++;
                if (addr !== 5'd0) begin
                    failures++;
                    $display("FAIL first_latch_addr got=%0d exp=0", addr);
                end
            end
            if (c < SL + BLANK + 1) @(negedge clk);
        end
        checks++;
        if (pulses != 64) begin
            failures++;
            $display("FAIL first_row_pulses got=%0d exp=64", pulses);
        end
        checks++;
        if (x !== 6'd0 || y !== 6'd1) begin
            failures++;
            $display("FAIL row1_start got x=%0d y=%0d exp x=0 y=1", x, y);
        end
    endtask

    task automatic test_scan_order();
        int ex;
        int ey;
        for (int k = 0; k < SL; k++) begin
            ex = (k < 128) ? k / 2 : 63;
            ey = 1 + 32 * ((k < 128) ? (k % 2) : 1);
            checks++;
            if (x !== 6'(ex) || y !== 6'(ey) || oe_n !== 1'b0) begin
                failures++;
                $display("FAIL scan_order k=%0d got x=%0d y=%0d oe_n=%b exp x=%0d y=%0d oe_n=0",
                         k, x, y, oe_n, ex, ey);
            end
            @(negedge clk);
        end
        checks++;
        if (oe_n !== 1'b1 || sclk !== 1'b0) begin
            failures++;
            $display("FAIL row1_blank got oe_n=%b sclk=%b exp oe_n=1 sclk=0", oe_n, sclk);
        end
    endtask

    task automatic test_subframe_advance();
        int g;
        g = 0;
        while (!(lat === 1'b1 && addr === 5'd31) && g < 32 * ROWP + 10) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (lat !== 1'b1 || addr !== 5'd31 || subframe !== 8'd0) begin
            failures++;
            $display("FAIL row31_latch got lat=%b addr=%0d sf=%0d exp lat=1 addr=31 sf=0",
                     lat, addr, subframe);
        end
        @(negedge clk);
        checks++;
        if (subframe !== 8'd1 || frame !== 16'd0) begin
            failures++;
            $display("FAIL subframe_inc got sf=%0d frame=%0d exp sf=1 frame=0", subframe, frame);
        end
        checks++;
        if (x !== 6'd0 || y !== 6'd0 || oe_n !== 1'b0) begin
            failures++;
            $display("FAIL row0_restart got x=%0d y=%0d oe_n=%b exp 0 0 0", x, y, oe_n);
        end
        xy_mode = 1'b1;
    endtask

    task automatic test_pairing();
        int       g;
        int       np;
        bit       ok;
        logic [2:0] e0;
        logic [2:0] e1;
        g = 0;
        while (subframe !== 8'd10 && g < 12 * 32 * ROWP) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (subframe !== 8'd10) begin
            failures++;
            $display("FAIL reach_sf10 got=%0d exp=10", subframe);
        end
        for (int row = 0; row < 16; row++) begin
            np = 0;
            g  = 0;
            while (lat !== 1'b1 && g < 2 * ROWP) begin
                if (sclk === 1'b1) begin
                    e0 = {lit(row, 10), 1'b0, lit(np, 10)};
                    e1 = {lit(row + 32, 10), 1'b0, lit(np, 10)};
                    checks++;
                    if (rgb0 !== e0 || rgb1 !== e1) begin
                        failures++;
                        $display("FAIL pairing row=%0d x=%0d got rgb0=%b rgb1=%b exp %b %b",
                                 row, np, rgb0, rgb1, e0, e1);
                    end
                    np++;
                end
                @(negedge clk);
                g++;
            end
            ok = (lat === 1'b1);
            checks++;
            if (!ok || np != 64 || addr !== 5'(row)) begin
                failures++;
                $display("FAIL pairing_row row=%0d got pulses=%0d addr=%0d exp 64 %0d",
                         row, np, addr, row);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pwm();
        logic [23:0] vecs [4];
        logic [2:0]  expv [4];
        bit          ok;
        vecs = '{24'h000080, 24'h340B80, 24'h0A36FF, 24'h0B0A00};
`ifdef LED_SCAN_GAMMA_EN
        expv = '{3'b001, 3'b001, 3'b011, 3'b000};
`else
        expv = '{3'b001, 3'b111, 3'b011, 3'b100};
`endif
        xy_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            const_rgb = vecs[i];
            @(negedge clk);
            wait_lat(ok);
            @(negedge clk);
            wait_lat(ok);
            checks++;
            if (!ok || subframe !== 8'd10) begin
                failures++;
                $display("FAIL pwm_setup vec=%h got lat=%b sf=%0d exp lat=1 sf=10",
                         vecs[i], lat, subframe);
            end
            checks++;
            if (rgb0 !== expv[i] || rgb1 !== expv[i]) begin
                failures++;
                $display("FAIL pwm vec=%h got rgb0=%b rgb1=%b exp=%b", vecs[i], rgb0, rgb1, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int row;
        int lows;
        row  = (int'(addr) + 1) % 32;
        lows = 0;
        @(negedge clk);
        repeat (40) @(negedge clk);
        checks++;
        if (oe_n !== 1'b0 || x !== 6'd20 || y !== 6'(row)) begin
            failures++;
            $display("FAIL pre_reset got oe_n=%b x=%0d y=%0d exp 0 20 %0d", oe_n, x, y, row);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (oe_n !== 1'b1) begin
            failures++;
            $display("FAIL midreset_oe_n got=%b exp=1", oe_n);
        end
        checks++;
        if ({frame, subframe, x, y, rgb0, rgb1, addr, sclk, lat} !== 49'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0",
                     {frame, subframe, x, y, rgb0, rgb1, addr, sclk, lat});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        for (int c = 0; c <= SL + BLANK; c++) begin
            if (oe_n !== 1'b1) lows++;
            if (c == 0 || c == CAP + 1 || c == CAP + 2) begin
                checks++;
                if (x !== 6'(c / 2) || y !== 6'(32 * (c % 2)) || sclk !== (c == CAP + 2)) begin
                    failures++;
                    $display("FAIL restart cycle=%0d got x=%0d y=%0d sclk=%b", c, x, y, sclk);
                end
            end
            if (c < SL + BLANK) @(negedge clk);
        end
        checks++;
        if (lat !== 1'b1 || addr !== 5'd0 || lows != 0) begin
            failures++;
            $display("FAIL restart_latch got lat=%b addr=%0d oe_low_cycles=%0d exp 1 0 0",
                     lat, addr, lows);
        end
    endtask

    task automatic test_wrap();
        int g;
        g = 0;
        resetn2 = 1'b1;
        while (!(lat2 === 1'b1 && addr2 === 5'd31 && sub2 === 8'd1 && frame2 === 1'b1)
               && g < 5 * 32 * ROWP) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (lat2 !== 1'b1 || sub2 !== 8'd1 || frame2 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_reach got lat=%b sf=%0d frame=%0d exp 1 1 1", lat2, sub2, frame2);
        end
        @(negedge clk);
        checks++;
        if (sub2 !== 8'd0 || frame2 !== 1'b0) begin
            failures++;
            $display("FAIL wrap got sf=%0d frame=%0d exp sf=0 frame=0", sub2, frame2);
        end
        checks++;
        if ({x2, y2, sclk2, lat2, oe2, addr2, rgb0_2, rgb1_2} !== {15'd0, 5'd31, 6'b111111}) begin
            failures++;
            $display("FAIL wrap_outputs got x=%0d y=%0d sclk=%b lat=%b oe_n=%b addr=%0d rgb=%b%b",
                     x2, y2, sclk2, lat2, oe2, addr2, rgb0_2, rgb1_2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_row();
        test_scan_order();
        test_subframe_advance();
        test_pairing();
        test_pwm();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
